mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Requester side of the 256x8 synchronous single-port RAM: drives the RAM's we/addr/d_i and captures its d_o.
- Serves single writes, plus single or incrementing burst reads, for the CPU core (instruction fetch and load/store) over a valid/ready request/response interface.
- Accounts for the RAM's 1-cycle registered read latency and its write-first behaviour.
- Stalls the response by holding the RAM address, so no read buffer is needed.

Parameters:
- ADDR_W, 8, RAM address width; addresses wrap modulo 2**ADDR_W.
- DATA_W, 8, data width.
- LEN_W, 2, burst length field width; a burst is req_len+1 beats, so 1..4 beats.

Ports:
- clk  in  1  rising-edge clock shared with the RAM.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  start address.
- req_wdata  in  DATA_W  write data.
- req_len  in  LEN_W  read beats minus 1; ignored for writes.
- rsp_valid  out  1  read data beat valid.
- rsp_ready  in  1  consumer accepts beat.
- rsp_data  out  DATA_W  read data.
- rsp_last  out  1  final beat of burst.
- mem_we  out  1  to RAM we.
- mem_addr  out  ADDR_W  to RAM addr.
- mem_din  out  DATA_W  to RAM d_i.
- mem_dout  in  DATA_W  from RAM d_o.

Behaviour:
- **Clock and reset:** one clock, clk; reset is synchronous and active-low, rst_n.
- **While rst_n = 0 at a clk edge:**
  - state <= IDLE; mem_we, mem_addr, mem_din, the beat counter and the address register <= 0.
  - rsp_valid = 0, rsp_last = 0.
  - req_ready = 0 while rst_n is low.
  - Reset mid-burst or mid-write abandons the operation with no further response. A write whose mem_we cycle has already ended stays written.
- **Registered outputs:** mem_we, mem_addr and mem_din are registered.
- **Combinational outputs:**
  - rsp_data = mem_dout.
  - req_ready = 1 only in IDLE with rst_n = 1.
  - rsp_valid = 1 only in RD_DATA.
  - rsp_last = 1 in RD_DATA when the beat counter = 0.
- **IDLE:** on req_valid && req_ready, latch the request.
  - Write: mem_addr <= req_addr, mem_din <= req_wdata, mem_we <= 1; go to WRITE.
  - Read: mem_addr <= req_addr, mem_we <= 0, counter <= req_len; go to RD_ADDR.
- **WRITE (1 cycle):** the RAM writes at the end of this cycle; mem_we <= 0; go to IDLE (or WR_CHK, see Optional Feature). Writes produce no response beat.
- **RD_ADDR (1 cycle):** the RAM samples mem_addr at the end of this cycle; go to RD_DATA.
- **RD_DATA:** rsp_valid = 1; mem_addr is held, so mem_dout stays stable under backpressure.
  - If rsp_ready = 0: remain in RD_DATA; rsp_data and rsp_last unchanged.
  - If rsp_ready = 1 and counter = 0: go to IDLE.
  - If rsp_ready = 1 and counter > 0: mem_addr <= mem_addr + 1 (ADDR_W wrap, 0xFF -> 0x00), counter <= counter - 1; go to RD_ADDR.
- **Latency:**
  - Read accepted at edge N: first beat valid in cycle N+2.
  - Each later beat is valid 2 cycles after the previous handshake.
  - Write accepted at edge N: req_ready returns in cycle N+2.
- **Write then read of the same address:** returns the new data (the RAM is write-first).
- **Request inputs outside IDLE:** ignored; req_ready = 0.
- **No simultaneous read and write:** mem_we is never 1 in RD_ADDR or RD_DATA.

Optional Feature:
- **Macro:** MEM_WR_VERIFY_EN.
- **When defined:**
  - Adds output port wr_err (1 bit) and state WR_CHK after WRITE. WR_CHK lasts 1 cycle, holds mem_addr, and keeps mem_we = 0.
  - In WR_CHK, mem_dout (which after the write-first edge must equal mem_din) is compared with mem_din.
  - A mismatch sets wr_err = 1. wr_err is sticky and cleared only by reset (reset value 0).
  - Write occupancy becomes 2 cycles; req_ready returns in cycle N+3.
- **When undefined:** no wr_err port; WRITE goes directly to IDLE; timing as in Behaviour.

Test Plan:
1. Reset hold 3 cycles with req_valid = 1 -> req_ready = 0, rsp_valid = 0, mem_we = 0, mem_addr = 0x00; no request accepted.
2. Write 0x10 <= 0xA5, then read 0x10 (len 0) -> mem_we high exactly 1 cycle with addr 0x10; read beat rsp_data = 0xA5, rsp_last = 1, valid 2 cycles after accept.
3. Preload 0x20..0x23 = 0x11, 0x22, 0x33, 0x44; burst read addr 0x20, len 3, rsp_ready = 1 -> 4 beats 0x11, 0x22, 0x33, 0x44, 2 cycles apart, rsp_last only on 0x44.
4. Burst read from 0xFE, len 3, with rsp_ready held low 5 cycles on beat 2 -> addresses 0xFE, 0xFF, 0x00, 0x01; beat 2 data stable throughout the stall.
5. Assert rst_n = 0 during beat 2 of a 4-beat burst -> next cycle rsp_valid = 0, state IDLE; after release, a new read of 0x20 returns 0x11.
6. With MEM_WR_VERIFY_EN: write 0x30 <= 0x5A with a RAM model that corrupts bit 0 -> wr_err = 1 from the cycle after WR_CHK until reset; a correct RAM keeps wr_err = 0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Requester for a 256x8 synchronous single-port RAM: single writes, single/burst reads.
// Optional write read-back check with sticky wr_err: define MEM_WR_VERIFY_EN.
module mem_access_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    // Handshakes: a transfer happens on a rising clk edge where valid && ready;
    // valid never depends on ready, and an unaccepted beat holds its payload.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
`ifdef MEM_WR_VERIFY_EN
    output logic              wr_err,
`endif
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        WR_CHK  = 3'd4
    } state_t;

    state_t              state_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   din_q;
    logic [LEN_W-1:0]    cnt_q;
`ifdef MEM_WR_VERIFY_EN
    logic                wr_err_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mem_we_q <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            cnt_q    <= '0;
`ifdef MEM_WR_VERIFY_EN
            wr_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q <= req_addr;
                        if (req_we) begin
                            din_q    <= req_wdata;
                            mem_we_q <= 1'b1;
                            state_q  <= WRITE;
                        end else begin
                            mem_we_q <= 1'b0;
                            cnt_q    <= req_len;
                            state_q  <= RD_ADDR;
                        end
                    end
                end
                WRITE: begin
                    mem_we_q <= 1'b0;
`ifdef MEM_WR_VERIFY_EN
                    state_q  <= WR_CHK;
`else
                    state_q  <= IDLE;
`endif
                end
`ifdef MEM_WR_VERIFY_EN
                // Write-first RAM already drives the just-written word here.
                WR_CHK: begin
                    if (mem_dout != din_q) begin
                        wr_err_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
`endif
                RD_ADDR: begin
                    state_q <= RD_DATA;
                end
                RD_DATA: begin
                    // Address is held while stalled, so the RAM keeps the beat stable.
                    if (rsp_ready) begin
                        if (cnt_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            addr_q  <= addr_q + 1'b1;
                            cnt_q   <= cnt_q - 1'b1;
                            state_q <= RD_ADDR;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = rst_n && (state_q == IDLE);
    assign rsp_valid = (state_q == RD_DATA);
    assign rsp_last  = (state_q == RD_DATA) && (cnt_q == '0);
    assign rsp_data  = mem_dout;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_din   = din_q;
    assign dbg_state = state_q;
`ifdef MEM_WR_VERIFY_EN
    assign wr_err    = wr_err_q;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a write-first 256x8 RAM model.
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic [1:0] req_len = 2'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       rsp_last;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;
    logic [2:0] dbg_state;
`ifdef MEM_WR_VERIFY_EN
    logic       wr_err;
`endif
    logic       corrupt = 1'b0;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(8), .DATA_W(8), .LEN_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_len   (req_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
`ifdef MEM_WR_VERIFY_EN
        .wr_err    (wr_err),
`endif
        .dbg_state (dbg_state)
    );

    // Write-first RAM; corrupt flips bit 0 of every written word.
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_din ^ {7'b0, corrupt};
            mem_dout      <= mem_din ^ {7'b0, corrupt};
        end else begin
            mem_dout <= ram[mem_addr];
        end
    end

    typedef struct {
        logic            we;
        logic [7:0]      addr;
        logic [7:0]      wdata;
        logic [1:0]      len;
        logic [3:0][7:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_timeout", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_len = 2'd0;
        @(posedge clk);
        #1 req_valid = 1'b0; req_we = 1'b0;
        @(negedge clk);
        check("wr_we_on", {31'b0, mem_we}, 32'd1);
        check("wr_addr", {24'b0, mem_addr}, {24'b0, a});
        check("wr_din", {24'b0, mem_din}, {24'b0, d});
        check("wr_busy", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        check("wr_we_off", {31'b0, mem_we}, 32'd0);
`ifdef MEM_WR_VERIFY_EN
        check("wr_chk_busy", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
`endif
        check("wr_ready_back", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [1:0] len, input logic [3:0][7:0] exp,
                           input int stall_beat, input int stall_cyc);
        int n;
        logic [7:0] ea;
        logic ok;
        ok = 1'b1;
        wait_ready();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_len = len;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            if (ok) begin
                ea = a + 8'(b);
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                    check("rd_no_we", {31'b0, mem_we}, 32'd0);
                end while (!rsp_valid && n < 8);
                check("rd_latency", n, 32'd2);
                if (!rsp_valid) begin
                    ok = 1'b0;
                end else begin
                    if (b == stall_beat) begin
                        rsp_ready = 1'b0;
                        for (int k = 0; k < stall_cyc; k++) begin
                            @(negedge clk);
                            check("stall_valid", {31'b0, rsp_valid}, 32'd1);
                            check("stall_data", {24'b0, rsp_data}, {24'b0, exp[b]});
                            check("stall_addr", {24'b0, mem_addr}, {24'b0, ea});
                        end
                        rsp_ready = 1'b1;
                    end
                    check("rd_data", {24'b0, rsp_data}, {24'b0, exp[b]});
                    check("rd_last", {31'b0, rsp_last}, {31'b0, (b == int'(len))});
                    check("rd_addr", {24'b0, mem_addr}, {24'b0, ea});
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 8'h10, 8'hA5, 2'd0, 32'h0};
        vecs[1]  = '{1'b0, 8'h10, 8'h00, 2'd0, 32'h000000A5};
        vecs[2]  = '{1'b1, 8'h20, 8'h11, 2'd0, 32'h0};
        vecs[3]  = '{1'b1, 8'h21, 8'h22, 2'd0, 32'h0};
        vecs[4]  = '{1'b1, 8'h22, 8'h33, 2'd0, 32'h0};
        vecs[5]  = '{1'b1, 8'h23, 8'h44, 2'd0, 32'h0};
        vecs[6]  = '{1'b0, 8'h20, 8'h00, 2'd3, 32'h44332211};
        vecs[7]  = '{1'b1, 8'hFE, 8'hC1, 2'd0, 32'h0};
        vecs[8]  = '{1'b1, 8'hFF, 8'hC2, 2'd0, 32'h0};
        vecs[9]  = '{1'b1, 8'h00, 8'hC3, 2'd0, 32'h0};
        vecs[10] = '{1'b1, 8'h01, 8'hC4, 2'd0, 32'h0};
        vecs[11] = '{1'b0, 8'hFF, 8'h00, 2'd1, 32'h0000C3C2};

        // Reset held with a pending write request: nothing may be accepted.
        rst_n = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h55; req_wdata = 8'hEE;
        repeat (3) begin
            @(negedge clk);
            check("rst_ready", {31'b0, req_ready}, 32'd0);
            check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            check("rst_mem_we", {31'b0, mem_we}, 32'd0);
            check("rst_mem_addr", {24'b0, mem_addr}, 32'h0);
        end
        req_valid = 1'b0; req_we = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_state", {29'b0, dbg_state}, 32'd0);
        check("post_rst_ready", {31'b0, req_ready}, 32'd1);
        check("post_rst_we", {31'b0, mem_we}, 32'd0);
        check("post_rst_last", {31'b0, rsp_last}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].we) do_write(vecs[i].addr, vecs[i].wdata);
            else            do_read(vecs[i].addr, vecs[i].len, vecs[i].exp, 4, 0);
        end

        // Wrapping burst with a 5-cycle stall on the second beat.
        do_read(8'hFE, 2'd3, 32'hC4C3C2C1, 1, 5);

        // Reset while the second beat of a 4-beat burst is being offered.
        wait_ready();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h20; req_len = 2'd3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rb_beat1", {24'b0, rsp_data}, 32'h11);
        @(posedge clk);
        #1;
        repeat (2) @(negedge clk);
        check("rb_beat2_valid", {31'b0, rsp_valid}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rb_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rb_state", {29'b0, dbg_state}, 32'd0);
        check("rb_ready_low", {31'b0, req_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rb_ready_back", {31'b0, req_ready}, 32'd1);
        check("rb_no_rsp", {31'b0, rsp_valid}, 32'd0);
        do_read(8'h20, 2'd0, 32'h00000011, 4, 0);

`ifdef MEM_WR_VERIFY_EN
        check("wr_err_clean", {31'b0, wr_err}, 32'd0);
        corrupt = 1'b1;
        do_write(8'h30, 8'h5A);
        check("wr_err_set", {31'b0, wr_err}, 32'd1);
        @(negedge clk);
        check("wr_err_sticky", {31'b0, wr_err}, 32'd1);
        corrupt = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("wr_err_rst", {31'b0, wr_err}, 32'd0);
        do_write(8'h30, 8'h5A);
        check("wr_err_good_ram", {31'b0, wr_err}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
